dbus_decoder: RTL

Parametrised data-bus decoder between the CPU data port and up to eight slave regions (RAM, I/O, ROM windows). It replaces the fixed two-way memory/I-O split at the system level with a programmable address map and routes write enables and read data. It also detects unmapped accesses, raises a trap pulse and records the first fault in software-visible status.

---
 rtl/dbus_decoder.sv | 110 +++++++++++
 1 files changed

// File: rtl/dbus_decoder.sv
// Data-bus decoder: maps CPU read/write addresses onto up to eight slave regions,
// muxes read data back with one cycle of latency and traps/records unmapped accesses.
module dbus_decoder #(
   parameter int NREGIONS = 2,
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter logic [ADDR_W*NREGIONS-1:0] REGION_BASE  = {16'h2000, 16'h0000},
   parameter logic [ADDR_W*NREGIONS-1:0] REGION_LIMIT = {16'hFFFF, 16'h1FFF},
   parameter logic [DATA_W-1:0] UNMAPPED_DATA = 16'h0000
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [ADDR_W-1:0]            dread_addr,
   input  logic                         dread_en,
   input  logic [ADDR_W-1:0]            dwrite_addr,
   input  logic [DATA_W/8-1:0]          dwrite_en,
   output logic [DATA_W-1:0]            dread_data,
   output logic [NREGIONS*DATA_W/8-1:0] slv_dwrite_en,
   input  logic [NREGIONS*DATA_W-1:0]   slv_dread_data,
   output logic                         trap,
   output logic [ADDR_W-1:0]            fault_addr,
   output logic                         fault_is_write,
   output logic                         fault_valid,
   output logic [7:0]                   fault_count,
   input  logic                         fault_clr
);

   localparam int BE_W  = DATA_W / 8;
   localparam int SEL_W = $clog2(NREGIONS + 1);
   localparam logic [SEL_W-1:0] NO_HIT = SEL_W'(NREGIONS);

   localparam logic [0:0] EMPTY = 1'b0;
   localparam logic [0:0] HELD  = 1'b1;

   logic [SEL_W-1:0] rd_sel;
   logic [SEL_W-1:0] wr_sel;
   logic [SEL_W-1:0] rsel;
   logic             rd_fault;
   logic             wr_fault;
   logic             any_fault;
   logic [1:0]       nfault;
   logic [8:0]       count_sum;
   logic [7:0]       count_next;
   logic [0:0]       state;

   // Scanning from the top index down lets the lowest matching region win on overlap.
   function automatic logic [SEL_W-1:0] region_of(input logic [ADDR_W-1:0] a);
      logic [SEL_W-1:0] idx;
      idx = NO_HIT;
      for (int i = NREGIONS - 1; i >= 0; i--) begin
         if (a >= REGION_BASE[i*ADDR_W +: ADDR_W] && a <= REGION_LIMIT[i*ADDR_W +: ADDR_W])
            idx = SEL_W'(i);
      end
      return idx;
   endfunction

   assign rd_sel    = region_of(dread_addr);
   assign wr_sel    = region_of(dwrite_addr);
   assign rd_fault  = dread_en && (rd_sel == NO_HIT);
   assign wr_fault  = (|dwrite_en) && (wr_sel == NO_HIT);
   assign any_fault = rd_fault || wr_fault;

   always_comb begin
      slv_dwrite_en = '0;
      for (int i = 0; i < NREGIONS; i++) begin
         if (wr_sel == SEL_W'(i))
            slv_dwrite_en[i*BE_W +: BE_W] = dwrite_en;
      end
   end

   // rsel is the registered select, so dread_data lines up with the slaves' read latency.
   always_comb begin
      dread_data = UNMAPPED_DATA;
      for (int i = 0; i < NREGIONS; i++) begin
         if (rsel == SEL_W'(i))
            dread_data = slv_dread_data[i*DATA_W +: DATA_W];
      end
   end

   assign nfault     = {1'b0, rd_fault} + {1'b0, wr_fault};
   assign count_sum  = {1'b0, fault_count} + {7'b0, nfault};
   assign count_next = fault_clr ? {6'b0, nfault} : (count_sum[8] ? 8'hFF : count_sum[7:0]);

   assign fault_valid = (state == HELD);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsel           <= NO_HIT;
         trap           <= 1'b0;
         fault_count    <= 8'd0;
         state          <= EMPTY;
         fault_addr     <= '0;
         fault_is_write <= 1'b0;
      end else begin
         rsel        <= rd_sel;
         trap        <= any_fault;
         fault_count <= count_next;
         // A clear in the same cycle as a new fault re-arms capture for that fault.
         if (any_fault && (state == EMPTY || fault_clr)) begin
            fault_addr     <= wr_fault ? dwrite_addr : dread_addr;
            fault_is_write <= wr_fault;
         end
         if (any_fault)
            state <= HELD;
         else if (fault_clr)
            state <= EMPTY;
      end
   end

endmodule
